// File: rtl/regfile_arb.sv
// rtl/regfile_arb.sv - two-master round-robin arbiter/sequencer for the control/status register file
// Optional lock re-grant (mN_lock_i ports) is built only when REGFILE_ARB_LOCK_EN is defined.
module regfile_arb #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic                m0_lock_i,
`endif
  output logic                m0_waitrequest_o,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic                m1_lock_i,
`endif
  output logic                m1_waitrequest_o,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  output logic [ADDR_W-1:0]   rf_addr_o,
  output logic [DATA_W-1:0]   rf_data_o,
  output logic [DATA_W/8-1:0] rf_be_o,
  output logic                rf_wren_o,
  input  logic [DATA_W-1:0]   rf_data_i,
  output logic [1:0]          grant_o,
  output logic                err_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [1:0]          grant_q, grant_d;
  logic                req0, req1, pick1, sel_read, sel_write;
`ifdef REGFILE_ARB_LOCK_EN
  logic [1:0]          cnt_q, cnt_d;
  logic                own_lock, other_req;
`endif

  always_comb begin
    req0  = m0_read_i | m0_write_i;
    req1  = m1_read_i | m1_write_i;
    // last_q = 1 means m1 was granted last, so m0 wins a tie
    pick1 = req1 & (~req0 | ~last_q);
`ifdef REGFILE_ARB_LOCK_EN
    own_lock  = grant_q[1] ? (m1_lock_i & req1) : (m0_lock_i & req0);
    other_req = grant_q[1] ? req0 : req1;
    if ((state_q == S_RESP) && own_lock && !(other_req && (cnt_q == 2'd3)))
      pick1 = grant_q[1];
`endif
    sel_read  = pick1 ? m1_read_i  : m0_read_i;
    sel_write = pick1 ? m1_write_i : m0_write_i;

    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    last_d   = last_q;
    err_d    = err_q;
    grant_d  = grant_q;
`ifdef REGFILE_ARB_LOCK_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_ACCESS: begin
        state_d = S_RESP;
        if (rd_q && grant_q[0]) rdata0_d = rf_data_i;
        if (rd_q && grant_q[1]) rdata1_d = rf_data_i;
      end
      default: begin
        // IDLE and RESP both arbitrate, so back-to-back transfers skip IDLE
        if (req0 || req1) begin
          state_d = S_ACCESS;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          addr_d  = pick1 ? m1_address_i    : m0_address_i;
          wdata_d = pick1 ? m1_writedata_i  : m0_writedata_i;
          be_d    = pick1 ? m1_byteenable_i : m0_byteenable_i;
          wr_d    = sel_write;
          rd_d    = sel_read & ~sel_write;
          if (sel_read && sel_write) err_d = 1'b1;
`ifdef REGFILE_ARB_LOCK_EN
          if ((state_q == S_RESP) && (pick1 == grant_q[1]) && other_req)
            cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
          else
            cnt_d = 2'd0;
`endif
        end else begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      grant_q  <= 2'b00;
`ifdef REGFILE_ARB_LOCK_EN
      cnt_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      last_q   <= last_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
`ifdef REGFILE_ARB_LOCK_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign rf_addr_o          = addr_q;
  assign rf_data_o          = wdata_q;
  assign rf_be_o            = be_q;
  assign rf_wren_o          = (state_q == S_ACCESS) && wr_q && (be_q != '0);
  assign grant_o            = grant_q;
  assign err_o              = err_q;
  assign m0_waitrequest_o   = !((state_q == S_ACCESS) && grant_q[0]);
  assign m1_waitrequest_o   = !((state_q == S_ACCESS) && grant_q[1]);
  assign m0_readdatavalid_o = (state_q == S_RESP) && grant_q[0] && rd_q;
  assign m1_readdatavalid_o = (state_q == S_RESP) && grant_q[1] && rd_q;
  assign m0_readdata_o      = rdata0_q;
  assign m1_readdata_o      = rdata1_q;

endmodule

// File: tb/tb_regfile_arb.sv
// tb/tb_regfile_arb.sv - directed self-checking bench for regfile_arb (default build, lock disabled)
module tb_regfile_arb;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_read_i, m0_write_i, m1_read_i, m1_write_i;
  logic [6:0]  m0_address_i, m1_address_i;
  logic [15:0] m0_writedata_i, m1_writedata_i;
  logic [1:0]  m0_byteenable_i, m1_byteenable_i;
  logic        m0_waitrequest_o, m1_waitrequest_o;
  logic [15:0] m0_readdata_o, m1_readdata_o;
  logic        m0_readdatavalid_o, m1_readdatavalid_o;
  logic [6:0]  rf_addr_o;
  logic [15:0] rf_data_o;
  logic [1:0]  rf_be_o;
  logic        rf_wren_o;
  logic [15:0] rf_data_i;
  logic [1:0]  grant_o;
  logic        err_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  regfile_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_read_i(m0_read_i), .m0_write_i(m0_write_i), .m0_address_i(m0_address_i),
    .m0_writedata_i(m0_writedata_i), .m0_byteenable_i(m0_byteenable_i),
    .m0_waitrequest_o(m0_waitrequest_o), .m0_readdata_o(m0_readdata_o),
    .m0_readdatavalid_o(m0_readdatavalid_o),
    .m1_read_i(m1_read_i), .m1_write_i(m1_write_i), .m1_address_i(m1_address_i),
    .m1_writedata_i(m1_writedata_i), .m1_byteenable_i(m1_byteenable_i),
    .m1_waitrequest_o(m1_waitrequest_o), .m1_readdata_o(m1_readdata_o),
    .m1_readdatavalid_o(m1_readdatavalid_o),
    .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_be_o(rf_be_o),
    .rf_wren_o(rf_wren_o), .rf_data_i(rf_data_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  // Register-file model: unwritten locations read back as 0xC000 | address
  bit [15:0]   mem [128];
  bit          valid [128];
  logic [15:0] merged;

  assign rf_data_i = valid[rf_addr_o] ? mem[rf_addr_o] : {9'h180, rf_addr_o};

  always_comb begin
    merged = rf_data_i;
    if (rf_be_o[0]) merged[7:0]  = rf_data_o[7:0];
    if (rf_be_o[1]) merged[15:8] = rf_data_o[15:8];
  end

  always @(posedge clk_i) begin
    if (rf_wren_o) begin
      mem[rf_addr_o]   <= merged;
      valid[rf_addr_o] <= 1'b1;
    end
  end

  task automatic clear_inputs();
    m0_read_i = 0; m0_write_i = 0; m0_address_i = '0; m0_writedata_i = '0; m0_byteenable_i = '0;
    m1_read_i = 0; m1_write_i = 0; m1_address_i = '0; m1_writedata_i = '0; m1_byteenable_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk_i);
    total_cnt++; if (m0_waitrequest_o !== 1'b1) $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest_o); else pass_cnt++;
    total_cnt++; if (m1_waitrequest_o !== 1'b1) $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest_o); else pass_cnt++;
    total_cnt++; if ({m0_readdatavalid_o, m1_readdatavalid_o} !== 2'b00) $display("FAIL rst_rdv: got %b want 00", {m0_readdatavalid_o, m1_readdatavalid_o}); else pass_cnt++;
    total_cnt++; if ({m0_readdata_o, m1_readdata_o} !== 32'h0) $display("FAIL rst_readdata: got %h want 0", {m0_readdata_o, m1_readdata_o}); else pass_cnt++;
    total_cnt++; if ({rf_addr_o, rf_data_o, rf_be_o, rf_wren_o} !== 26'h0) $display("FAIL rst_rf: got %h want 0", {rf_addr_o, rf_data_o, rf_be_o, rf_wren_o}); else pass_cnt++;
    total_cnt++; if ({grant_o, err_o} !== 3'b000) $display("FAIL rst_grant_err: got %b want 000", {grant_o, err_o}); else pass_cnt++;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_write_read();
    m0_write_i = 1; m0_address_i = 7'h05; m0_writedata_i = 16'hA55A; m0_byteenable_i = 2'b11;
    step();
    total_cnt++; if (rf_wren_o !== 1'b1) $display("FAIL wr_access_wren: got %b want 1", rf_wren_o); else pass_cnt++;
    total_cnt++; if (rf_addr_o !== 7'h05) $display("FAIL wr_access_addr: got %h want 05", rf_addr_o); else pass_cnt++;
    total_cnt++; if ({rf_data_o, rf_be_o} !== {16'hA55A, 2'b11}) $display("FAIL wr_access_data_be: got %h want %h", {rf_data_o, rf_be_o}, {16'hA55A, 2'b11}); else pass_cnt++;
    total_cnt++; if ({m0_waitrequest_o, m1_waitrequest_o} !== 2'b01) $display("FAIL wr_access_wait: got %b want 01", {m0_waitrequest_o, m1_waitrequest_o}); else pass_cnt++;
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL wr_access_grant: got %b want 01", grant_o); else pass_cnt++;
    m0_write_i = 0;
    step();
    total_cnt++; if (rf_wren_o !== 1'b0) $display("FAIL wr_resp_wren: got %b want 0", rf_wren_o); else pass_cnt++;
    total_cnt++; if (m0_readdatavalid_o !== 1'b0) $display("FAIL wr_resp_rdv: got %b want 0", m0_readdatavalid_o); else pass_cnt++;
    total_cnt++; if ({grant_o, m0_waitrequest_o} !== 3'b011) $display("FAIL wr_resp_grant_wait: got %b want 011", {grant_o, m0_waitrequest_o}); else pass_cnt++;
    step();
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL wr_idle_grant: got %b want 00", grant_o); else pass_cnt++;
    total_cnt++; if (mem[5] !== 16'hA55A) $display("FAIL wr_mem05: got %h want a55a", mem[5]); else pass_cnt++;
    m0_read_i = 1; m0_address_i = 7'h05;
    step();
    total_cnt++; if ({m0_waitrequest_o, rf_wren_o} !== 2'b00) $display("FAIL rd_access_wait_wren: got %b want 00", {m0_waitrequest_o, rf_wren_o}); else pass_cnt++;
    m0_read_i = 0;
    step();
    total_cnt++; if (m0_readdatavalid_o !== 1'b1) $display("FAIL rd_resp_rdv: got %b want 1", m0_readdatavalid_o); else pass_cnt++;
    total_cnt++; if (m0_readdata_o !== 16'hA55A) $display("FAIL rd_resp_data: got %h want a55a", m0_readdata_o); else pass_cnt++;
    total_cnt++; if (m1_readdatavalid_o !== 1'b0) $display("FAIL rd_resp_m1_rdv: got %b want 0", m1_readdatavalid_o); else pass_cnt++;
    step();
    total_cnt++; if (m0_readdatavalid_o !== 1'b0) $display("FAIL rd_after_rdv: got %b want 0", m0_readdatavalid_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] g_tab;
    logic [5:0]  v0_tab, v1_tab;
    g_tab  = 12'b01_01_10_10_01_01;
    v0_tab = 6'b010001;
    v1_tab = 6'b000100;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m0_read_i = 1; m0_address_i = 7'h10;
    m1_read_i = 1; m1_address_i = 7'h20;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++; if (grant_o !== g_tab[11-2*i -: 2]) $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_o, g_tab[11-2*i -: 2]); else pass_cnt++;
      total_cnt++; if (m0_readdatavalid_o !== v0_tab[5-i]) $display("FAIL rr_m0_rdv[%0d]: got %b want %b", i, m0_readdatavalid_o, v0_tab[5-i]); else pass_cnt++;
      total_cnt++; if (m1_readdatavalid_o !== v1_tab[5-i]) $display("FAIL rr_m1_rdv[%0d]: got %b want %b", i, m1_readdatavalid_o, v1_tab[5-i]); else pass_cnt++;
      if (i == 1) begin
        total_cnt++; if (m0_readdata_o !== 16'hC010) $display("FAIL rr_m0_data: got %h want c010", m0_readdata_o); else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++; if (m1_readdata_o !== 16'hC020) $display("FAIL rr_m1_data: got %h want c020", m1_readdata_o); else pass_cnt++;
        total_cnt++; if (m0_readdata_o !== 16'hC010) $display("FAIL rr_m0_hold: got %h want c010", m0_readdata_o); else pass_cnt++;
      end
    end
    m0_read_i = 0; m1_read_i = 0;
    step();
    total_cnt++; if (grant_o !== 2'b00) $display("FAIL rr_idle_grant: got %b want 00", grant_o); else pass_cnt++;
  endtask

  task automatic test_be_zero_and_err();
    int wait_low = 0;
    int wren_seen = 0;
    m1_write_i = 1; m1_address_i = 7'h30; m1_writedata_i = 16'hFFFF; m1_byteenable_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_wren_o) wren_seen++;
      if (!m1_waitrequest_o) begin
        wait_low++;
        m1_write_i = 0;
      end
    end
    total_cnt++; if (wait_low !== 1) $display("FAIL be0_wait_cycles: got %0d want 1", wait_low); else pass_cnt++;
    total_cnt++; if (wren_seen !== 0) $display("FAIL be0_wren_cycles: got %0d want 0", wren_seen); else pass_cnt++;
    total_cnt++; if (valid[7'h30] !== 1'b0) $display("FAIL be0_mem_touched: got %b want 0", valid[7'h30]); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL be0_err: got %b want 0", err_o); else pass_cnt++;
    m0_read_i = 1; m0_write_i = 1; m0_address_i = 7'h31; m0_writedata_i = 16'hBEEF; m0_byteenable_i = 2'b11;
    step();
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else pass_cnt++;
    total_cnt++; if ({rf_wren_o, m0_waitrequest_o} !== 2'b10) $display("FAIL err_access_wren_wait: got %b want 10", {rf_wren_o, m0_waitrequest_o}); else pass_cnt++;
    m0_read_i = 0; m0_write_i = 0;
    step();
    total_cnt++; if (m0_readdatavalid_o !== 1'b0) $display("FAIL err_no_rdv: got %b want 0", m0_readdatavalid_o); else pass_cnt++;
    repeat (2) step();
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else pass_cnt++;
    total_cnt++; if (mem[7'h31] !== 16'hBEEF) $display("FAIL err_write_done: got %h want beef", mem[7'h31]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int rdv_seen = 0;
    int wren_seen = 0;
    m0_read_i = 1; m0_address_i = 7'h10;
    step();
    total_cnt++; if (m0_waitrequest_o !== 1'b0) $display("FAIL rm_access_wait: got %b want 0", m0_waitrequest_o); else pass_cnt++;
    rst_i = 1'b1;
    #1;
    total_cnt++; if ({m0_waitrequest_o, m1_waitrequest_o} !== 2'b11) $display("FAIL rm_wait: got %b want 11", {m0_waitrequest_o, m1_waitrequest_o}); else pass_cnt++;
    total_cnt++; if ({grant_o, err_o} !== 3'b000) $display("FAIL rm_grant_err: got %b want 000", {grant_o, err_o}); else pass_cnt++;
    total_cnt++; if ({rf_addr_o, rf_wren_o} !== 8'h00) $display("FAIL rm_rf: got %h want 00", {rf_addr_o, rf_wren_o}); else pass_cnt++;
    total_cnt++; if (m0_readdata_o !== 16'h0000) $display("FAIL rm_readdata: got %h want 0000", m0_readdata_o); else pass_cnt++;
    m0_read_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m0_readdatavalid_o) rdv_seen++;
      if (rf_wren_o) wren_seen++;
    end
    total_cnt++; if (rdv_seen !== 0) $display("FAIL rm_rdv_after: got %0d want 0", rdv_seen); else pass_cnt++;
    total_cnt++; if (wren_seen !== 0) $display("FAIL rm_wren_after: got %0d want 0", wren_seen); else pass_cnt++;
  endtask

  task automatic test_resp_handoff();
    m0_write_i = 1; m0_address_i = 7'h40; m0_writedata_i = 16'h0042; m0_byteenable_i = 2'b11;
    step();
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL ho_m0_access: got %b want 01", grant_o); else pass_cnt++;
    m0_write_i = 0;
    step();
    total_cnt++; if (grant_o !== 2'b01) $display("FAIL ho_m0_resp: got %b want 01", grant_o); else pass_cnt++;
    m1_read_i = 1; m1_address_i = 7'h40;
    step();
    total_cnt++; if ({grant_o, m1_waitrequest_o} !== 3'b100) $display("FAIL ho_m1_access: got %b want 100", {grant_o, m1_waitrequest_o}); else pass_cnt++;
    m1_read_i = 0;
    step();
    total_cnt++; if (m1_readdatavalid_o !== 1'b1) $display("FAIL ho_m1_rdv: got %b want 1", m1_readdatavalid_o); else pass_cnt++;
    total_cnt++; if (m1_readdata_o !== 16'h0042) $display("FAIL ho_m1_data: got %h want 0042", m1_readdata_o); else pass_cnt++;
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_be_zero_and_err();
    test_reset_mid();
    test_resp_handoff();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
